// File: rtl/mp_pkg.sv
// Shared definitions for the multipump memory-port family: width defaults and
// the two-phase port-cycle encoding.
package mp_pkg;

  localparam int MP_ADDR_W = 64;
  localparam int MP_DATA_W = 64;
  localparam int MP_BE_W   = MP_DATA_W / 8;

  typedef enum logic {
    PH_P0 = 1'b0,
    PH_P1 = 1'b1
  } phase_t;

endpackage

// File: rtl/mp_2ports.sv
// Two-port front end over one memory master. It runs on the 2x clock and time-slices
// port 0 (phase 0) and port 1 (phase 1) onto the shared avm request.
module mp_2ports
  import mp_pkg::*;
#(
  parameter int ADDR_W = MP_ADDR_W,
  parameter int DATA_W = MP_DATA_W,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clock,
  input  logic              resetn,

  input  logic [ADDR_W-1:0] addr_0,
  input  logic              write_en_0,
  input  logic              read_en_0,
  input  logic [BE_W-1:0]   byte_en_0,
  input  logic [DATA_W-1:0] write_data_0,
  output logic [DATA_W-1:0] read_data_0,

  input  logic [ADDR_W-1:0] addr_1,
  input  logic              write_en_1,
  input  logic              read_en_1,
  input  logic [BE_W-1:0]   byte_en_1,
  input  logic [DATA_W-1:0] write_data_1,
  output logic [DATA_W-1:0] read_data_1,

  output logic [ADDR_W-1:0] avm_addr,
  output logic              avm_write_en,
  output logic              avm_read_en,
  output logic [BE_W-1:0]   avm_byte_en,
  output logic [DATA_W-1:0] avm_write_data,
  input  logic [DATA_W-1:0] avm_read_data
);

  phase_t            r_phase;
  logic              r_pend_0;
  logic              r_pend_1;
  logic [DATA_W-1:0] r_read_data_0;
  logic [DATA_W-1:0] r_read_data_1;

  logic              w_rd_0;
  logic              w_rd_1;
  logic              w_issue_rd_0;
  logic              w_issue_rd_1;

  // A write on the same port in the same cycle takes precedence over the read.
  assign w_rd_0 = read_en_0 & ~write_en_0;
  assign w_rd_1 = read_en_1 & ~write_en_1;

  assign w_issue_rd_0 = (r_phase == PH_P0) & w_rd_0;
  assign w_issue_rd_1 = (r_phase == PH_P1) & w_rd_1;

  always_comb begin
    avm_addr       = addr_0;
    avm_write_en   = write_en_0;
    avm_read_en    = w_rd_0;
    avm_byte_en    = byte_en_0;
    avm_write_data = write_data_0;
    if (r_phase == PH_P1) begin
      avm_addr       = addr_1;
      avm_write_en   = write_en_1;
      avm_read_en    = w_rd_1;
      avm_byte_en    = byte_en_1;
      avm_write_data = write_data_1;
    end
    // Enables are gated directly by reset so no request escapes while it is low.
    avm_write_en = avm_write_en & resetn;
    avm_read_en  = avm_read_en & resetn;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_phase <= PH_P0;
    end else begin
      r_phase <= (r_phase == PH_P0) ? PH_P1 : PH_P0;
    end
  end

  // Each pending flag is only ever set at the end of its own phase, so a set flag
  // means the memory data for that port is on avm_read_data this cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pend_0      <= 1'b0;
      r_read_data_0 <= '0;
    end else if (r_pend_0) begin
      r_pend_0      <= 1'b0;
      r_read_data_0 <= avm_read_data;
    end else if (w_issue_rd_0) begin
      r_pend_0      <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pend_1      <= 1'b0;
      r_read_data_1 <= '0;
    end else if (r_pend_1) begin
      r_pend_1      <= 1'b0;
      r_read_data_1 <= avm_read_data;
    end else if (w_issue_rd_1) begin
      r_pend_1      <= 1'b1;
    end
  end

  assign read_data_0 = r_read_data_0;
  assign read_data_1 = r_read_data_1;

endmodule

// File: tb/tb_mp_2ports.sv
// Directed bench for mp_2ports with a 1-cycle-latency byte-enabled memory model
// and queued expected read results per port.
module tb_mp_2ports;

  logic        clock;
  logic        resetn;
  logic [63:0] addr_0, addr_1;
  logic        write_en_0, write_en_1;
  logic        read_en_0, read_en_1;
  logic [7:0]  byte_en_0, byte_en_1;
  logic [63:0] write_data_0, write_data_1;
  logic [63:0] read_data_0, read_data_1;
  logic [63:0] avm_addr;
  logic        avm_write_en, avm_read_en;
  logic [7:0]  avm_byte_en;
  logic [63:0] avm_write_data;
  logic [63:0] avm_read_data;

  int checks = 0;
  int errors = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] hold0, hold1;
  int          pend1_cnt;

  logic [63:0] mem [0:511];

  mp_2ports dut (
    .clock         (clock),
    .resetn        (resetn),
    .addr_0        (addr_0),
    .write_en_0    (write_en_0),
    .read_en_0     (read_en_0),
    .byte_en_0     (byte_en_0),
    .write_data_0  (write_data_0),
    .read_data_0   (read_data_0),
    .addr_1        (addr_1),
    .write_en_1    (write_en_1),
    .read_en_1     (read_en_1),
    .byte_en_1     (byte_en_1),
    .write_data_1  (write_data_1),
    .read_data_1   (read_data_1),
    .avm_addr      (avm_addr),
    .avm_write_en  (avm_write_en),
    .avm_read_en   (avm_read_en),
    .avm_byte_en   (avm_byte_en),
    .avm_write_data(avm_write_data),
    .avm_read_data (avm_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] be_merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                           input logic [7:0] be);
    logic [63:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  always @(posedge clock) begin
    if (avm_read_en) avm_read_data <= mem[avm_addr[8:0]];
    if (avm_write_en)
      mem[avm_addr[8:0]] <= be_merge(mem[avm_addr[8:0]], avm_write_data, avm_byte_en);
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    addr_0 = '0; write_en_0 = 0; read_en_0 = 0; byte_en_0 = '0; write_data_0 = '0;
    addr_1 = '0; write_en_1 = 0; read_en_1 = 0; byte_en_1 = '0; write_data_1 = '0;
  endtask

  // Called right after the edge that starts phase 0; returns after the edge that ends phase 1.
  task automatic port_cycle(
    input logic [63:0] a0, input logic we0, input logic re0, input logic [7:0] be0,
    input logic [63:0] wd0, input logic [63:0] e0,
    input logic [63:0] a1, input logic we1, input logic re1, input logic [7:0] be1,
    input logic [63:0] wd1, input logic [63:0] e1);
    logic [63:0] exp;
    addr_0 = a0; write_en_0 = we0; read_en_0 = re0; byte_en_0 = be0; write_data_0 = wd0;
    addr_1 = a1; write_en_1 = we1; read_en_1 = re1; byte_en_1 = be1; write_data_1 = wd1;
    if (re0 && !we0) q0.push_back(e0);
    if (re1 && !we1) q1.push_back(e1);
    @(negedge clock);
    chk("ph0_addr", avm_addr, a0);
    chk("ph0_we", {63'd0, avm_write_en}, {63'd0, we0});
    chk("ph0_re", {63'd0, avm_read_en}, {63'd0, re0 & ~we0});
    if (we0) begin
      chk("ph0_be", {56'd0, avm_byte_en}, {56'd0, be0});
      chk("ph0_wd", avm_write_data, wd0);
    end
    @(posedge clock); #1;
    @(negedge clock);
    chk("ph1_addr", avm_addr, a1);
    chk("ph1_we", {63'd0, avm_write_en}, {63'd0, we1});
    chk("ph1_re", {63'd0, avm_read_en}, {63'd0, re1 & ~we1});
    if (we1) begin
      chk("ph1_be", {56'd0, avm_byte_en}, {56'd0, be1});
      chk("ph1_wd", avm_write_data, wd1);
    end
    if (pend1_cnt > 0) begin
      exp = q1.pop_front();
      chk("rd1", read_data_1, exp);
      hold1 = exp;
      pend1_cnt--;
    end else begin
      chk("rd1_hold", read_data_1, hold1);
    end
    if (re1 && !we1) pend1_cnt++;
    @(posedge clock); #1;
    if (re0 && !we0) begin
      exp = q0.pop_front();
      chk("rd0", read_data_0, exp);
      hold0 = exp;
    end else begin
      chk("rd0_hold", read_data_0, hold0);
    end
  endtask

  task automatic idle_cycle();
    port_cycle(64'h0, 0, 0, 8'h00, 64'h0, 64'h0, 64'h0, 0, 0, 8'h00, 64'h0, 64'h0);
  endtask

  initial begin
    hold0 = '0; hold1 = '0; pend1_cnt = 0;
    idle_inputs();
    resetn = 1'b0;
    write_en_0 = 1; read_en_0 = 1; read_en_1 = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_rd0", read_data_0, 64'h0);
    chk("rst_rd1", read_data_1, 64'h0);
    chk("rst_avm_we", {63'd0, avm_write_en}, 64'h0);
    chk("rst_avm_re", {63'd0, avm_read_en}, 64'h0);
    idle_inputs();
    @(posedge clock); #1;
    resetn = 1'b1;

    // Preload memory through the ports.
    port_cycle(64'h7f, 1, 0, 8'hff, 64'hdeadbeef, 64'h0, 64'hff, 1, 0, 8'hff, 64'hbeefdead, 64'h0);
    port_cycle(64'h17f, 1, 0, 8'hff, 64'h0123456789abcdef, 64'h0,
               64'h1ff, 1, 0, 8'hff, 64'hfedcba9876543210, 64'h0);
    port_cycle(64'h60, 1, 0, 8'hff, 64'haa, 64'h0, 64'h80, 1, 0, 8'hff, 64'h1111111111111111, 64'h0);

    // Dual read, then a back-to-back pair.
    port_cycle(64'h7f, 0, 1, 8'hff, 64'h0, 64'hdeadbeef, 64'hff, 0, 1, 8'hff, 64'h0, 64'hbeefdead);
    port_cycle(64'h17f, 0, 1, 8'hff, 64'h0, 64'h0123456789abcdef,
               64'h1ff, 0, 1, 8'hff, 64'h0, 64'hfedcba9876543210);

    // Same-address ordering cases.
    port_cycle(64'h40, 1, 0, 8'hff, 64'h11, 64'h0, 64'h40, 1, 0, 8'hff, 64'h22, 64'h0);
    port_cycle(64'h40, 0, 1, 8'hff, 64'h0, 64'h22, 64'h80, 1, 0, 8'h0f, 64'h2222222222222222, 64'h0);
    port_cycle(64'h50, 1, 0, 8'hff, 64'h33, 64'h0, 64'h50, 0, 1, 8'hff, 64'h0, 64'h33);
    port_cycle(64'h60, 0, 1, 8'hff, 64'h0, 64'haa, 64'h60, 1, 0, 8'hff, 64'hbb, 64'h0);

    // Write+read on port 0 issues only the write; read_data_0 must hold.
    port_cycle(64'h60, 1, 1, 8'hff, 64'hcc, 64'h0, 64'h80, 0, 1, 8'hff, 64'h0, 64'h1111111122222222);
    port_cycle(64'h60, 0, 1, 8'hff, 64'h0, 64'hcc, 64'h40, 0, 1, 8'hff, 64'h0, 64'h22);

    repeat (5) idle_cycle();

    // Reset in the middle of a port-0 read.
    addr_0 = 64'h7f; read_en_0 = 1;
    @(posedge clock); #1;
    resetn = 1'b0;
    #1;
    chk("midrst_rd0", read_data_0, 64'h0);
    chk("midrst_rd1", read_data_1, 64'h0);
    chk("midrst_avm_re", {63'd0, avm_read_en}, 64'h0);
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    hold0 = '0; hold1 = '0; pend1_cnt = 0;
    q0.delete(); q1.delete();
    repeat (3) idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mp_2ports.md
MP_2PORTS -- requirements
Module: mp_2ports

Interface
REQ-001 Parameter ADDR_W, default 64, SHALL set the address width of both ports and avm_addr.
REQ-002 Parameter DATA_W, default 64, SHALL set the data width of write/read data.
REQ-003 Parameter BE_W, default DATA_W/8 (8), SHALL set the byte-enable width.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clock  in  1  single clock (the 2x memory clock); all state changes on its rising edge.
REQ-006 resetn  in  1  asynchronous active-low reset.
REQ-007 addr_0 / addr_1  in  ADDR_W  port 0 / port 1 word address.
REQ-008 write_en_0 / write_en_1  in  1  port write request.
REQ-009 read_en_0 / read_en_1  in  1  port read request.
REQ-010 byte_en_0 / byte_en_1  in  BE_W  port byte enables.
REQ-011 write_data_0 / write_data_1  in  DATA_W  port write data.
REQ-012 read_data_0 / read_data_1  out  DATA_W  registered port read data.
REQ-013 avm_addr  out  ADDR_W; avm_write_en  out  1; avm_read_en  out  1; avm_byte_en  out  BE_W; avm_write_data  out  DATA_W: the shared memory-master request.
REQ-014 avm_read_data  in  DATA_W: memory read data, fixed 1-cycle latency.

Function
REQ-015 A 1-bit phase register SHALL toggle every clock; two consecutive cycles (phase 0, then phase 1) form one port cycle.
REQ-016 Port inputs SHALL be held stable by the requester for the whole port cycle, from phase 0 through phase 1.
REQ-017 In phase 0, the avm_* outputs SHALL combinationally carry port 0 fields; in phase 1, they SHALL carry port 1 fields.
REQ-018 Per port, if write_en and read_en are both 1, the write SHALL be issued and the read SHALL be suppressed (avm_read_en=0).
REQ-019 avm_write_en and avm_read_en SHALL be 0 while resetn=0.
REQ-020 A port-0 read issued in phase 0 SHALL set pend_0; at the rising edge ending the next (phase 1) cycle, read_data_0 SHALL load avm_read_data and pend_0 SHALL clear.
REQ-021 A port-1 read issued in phase 1 SHALL set pend_1; at the rising edge ending the next (phase 0) cycle, read_data_1 SHALL load avm_read_data and pend_1 SHALL clear.
REQ-022 read_data_0 and read_data_1 SHALL hold their value when no read for that port is pending.
REQ-023 Same-address access SHALL resolve in port order: port 0 is serviced before port 1.
  - Both ports write: port 1 data wins.
  - Port 0 writes, port 1 reads: port 1 returns the new data.
  - Port 0 reads, port 1 writes: port 0 returns the old data.
REQ-024 Byte enables SHALL pass through unmodified; no address translation is applied.

Reset
REQ-025 While resetn=0, the following SHALL be 0: phase, pend_0, pend_1, read_data_0, read_data_1.
REQ-026 A reset asserted mid-operation SHALL discard pending reads, with no read_data update afterwards.
REQ-027 The first cycle after reset release SHALL be phase 0.

Structure
REQ-028 The width defaults (ADDR_W, DATA_W, BE_W) SHALL live in the shared package mp_pkg, for use by all multipump blocks.
REQ-029 The design SHALL be flat, with no sub-module.
REQ-030 Logic SHALL consist of:
  - the phase flop;
  - the 2:1 avm request mux;
  - two pending flops;
  - two read-data registers.

Verification
REQ-031 Reset: assert resetn=0 mid-read -> read_data_0 = read_data_1 = 0, avm_read_en = 0, and no later update.
REQ-032 Dual read: addr_0=0x7f, addr_1=0xff, both read_en=1 ->
  - avm_addr = 0x7f in phase 0, then 0xff in phase 1;
  - memory returns 0xdeadbeef in phase 1 -> read_data_0 = 0xdeadbeef;
  - memory returns 0xbeefdead in the next phase 0 -> read_data_1 = 0xbeefdead.
REQ-033 Back-to-back: next port cycle with addr_0=0x17f, addr_1=0x1ff -> avm_addr sequence is 0x7f, 0xff, 0x17f, 0x1ff, with no bubble.
REQ-034 Write collision: both ports write addr 0x40, data 0x11 (port 0) and 0x22 (port 1), byte_en=0xff -> avm writes 0x11 then 0x22; a later read returns 0x22.
REQ-035 Write+read conflict on port 0 (write_en_0 = read_en_0 = 1) -> avm_write_en=1, avm_read_en=0 in phase 0, and read_data_0 is unchanged.
REQ-036 Idle: all enables 0 -> avm enables 0 and read data held, for 10 cycles.
